hack_ctrl_seq: RTL and testbench

- Multicycle control sequencer that issues 6-bit ALU operations and consumes the ALU's out/zr/ng results.
- It is the producing end of the ALU op interface: it fetches 16-bit Hack-format instructions, holds the A, D and PC registers, and drives the ALU operands and op.
- It performs data-memory read and write with a req/ack handshake and resolves jumps from zr/ng.
- It sits between the instruction/data memories and a combinational ALU.

---
 rtl/hack_ctrl_seq.sv | 192 +++++++++++++++++++
 tb/tb_hack_ctrl_seq.sv | 286 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/hack_ctrl_seq.sv
// hack_ctrl_seq - multicycle control sequencer for a Hack-style CPU.
//
// Fetches 16-bit Hack instructions and holds the A, D, PC, IR and MDR registers.
// It drives the operands and op of an external combinational ALU. Data memory is
// reached through a req/ack handshake, and jumps are resolved from the ALU's
// zr/ng flags.
//
// Ports:
//   clk, rst                 clock; synchronous active-high reset
//   imem_req/addr/ack/data   instruction fetch handshake (addr = PC)
//   dmem_rd/wr/addr          data memory request; addr = A before the instruction
//   dmem_wdata/rdata/ack     write data, read data, completion
//   alu_x/alu_y/alu_op       ALU operands (D, A or MDR) and op = ir[11:6]
//   alu_out/alu_zr/alu_ng    ALU result and flags
//   pc_out                   current PC
//   retire                   one-cycle pulse when an instruction completes
//   halted                   trap status
//
// Optional feature: define ILLEGAL_TRAP_EN to trap C-instructions whose
// ir[14:13] != 2'b11 into a HALT state. HALT is left only through rst.
// Without the macro those bits are ignored and halted is tied low.
module hack_ctrl_seq #(
    parameter int unsigned DATA_W   = 16,
    parameter int unsigned ADDR_W   = 15,
    parameter int unsigned RESET_PC = 0
) (
    input  logic              clk,
    input  logic              rst,
    output logic              imem_req,
    output logic [ADDR_W-1:0] imem_addr,
    input  logic              imem_ack,
    input  logic [DATA_W-1:0] imem_data,
    output logic              dmem_rd,
    output logic              dmem_wr,
    output logic [ADDR_W-1:0] dmem_addr,
    output logic [DATA_W-1:0] dmem_wdata,
    input  logic [DATA_W-1:0] dmem_rdata,
    input  logic              dmem_ack,
    output logic [DATA_W-1:0] alu_x,
    output logic [DATA_W-1:0] alu_y,
    output logic [5:0]        alu_op,
    input  logic [DATA_W-1:0] alu_out,
    input  logic              alu_zr,
    input  logic              alu_ng,
    output logic [ADDR_W-1:0] pc_out,
    output logic              retire,
    output logic              halted
);

    localparam logic [2:0] ST_FETCH  = 3'd0;
    localparam logic [2:0] ST_DECODE = 3'd1;
    localparam logic [2:0] ST_MEM_RD = 3'd2;
    localparam logic [2:0] ST_EXEC   = 3'd3;
    localparam logic [2:0] ST_MEM_WR = 3'd4;
`ifdef ILLEGAL_TRAP_EN
    localparam logic [2:0] ST_HALT   = 3'd5;
`endif

    localparam logic [ADDR_W-1:0] RESET_PC_V = ADDR_W'(RESET_PC);

    logic [2:0]        state;
    logic [ADDR_W-1:0] pc;
    logic [DATA_W-1:0] a_reg;
    logic [DATA_W-1:0] d_reg;
    logic [DATA_W-1:0] mdr;
    logic [DATA_W-1:0] ir;
    logic [DATA_W-1:0] res;
    logic              zr_q;
    logic              ng_q;

    logic [ADDR_W-1:0] pc_inc;
    logic [DATA_W-1:0] commit_val;
    logic              commit_zr;
    logic              commit_ng;
    logic              jump_taken;
    logic [ADDR_W-1:0] commit_pc;

    assign pc_inc = pc + ADDR_W'(1);

    // EXEC commits straight from the ALU when there is no M write. MEM_WR commits
    // from the values latched at the end of EXEC.
    always_comb begin
        commit_val = res;
        commit_zr  = zr_q;
        commit_ng  = ng_q;
        if (state == ST_EXEC) begin
            commit_val = alu_out;
            commit_zr  = alu_zr;
            commit_ng  = alu_ng;
        end
    end

    assign jump_taken = (ir[2] & commit_ng) | (ir[1] & commit_zr) |
                        (ir[0] & ~commit_zr & ~commit_ng);
    // The jump target is the A value from before this instruction. A is only
    // written at commit, so a_reg still holds that value here.
    assign commit_pc  = jump_taken ? a_reg[ADDR_W-1:0] : pc_inc;

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= ST_FETCH;
            pc    <= RESET_PC_V;
            a_reg <= '0;
            d_reg <= '0;
            mdr   <= '0;
            ir    <= '0;
            res   <= '0;
            zr_q  <= 1'b0;
            ng_q  <= 1'b0;
        end else begin
            case (state)
                ST_FETCH: begin
                    if (imem_ack) begin
                        ir    <= imem_data;
                        state <= ST_DECODE;
                    end
                end
                ST_DECODE: begin
                    if (!ir[15]) begin
                        a_reg <= ir;
                        pc    <= pc_inc;
                        state <= ST_FETCH;
                    end
`ifdef ILLEGAL_TRAP_EN
                    else if (ir[14:13] != 2'b11) begin
                        state <= ST_HALT;
                    end
`endif
                    else if (ir[12]) begin
                        state <= ST_MEM_RD;
                    end else begin
                        state <= ST_EXEC;
                    end
                end
                ST_MEM_RD: begin
                    if (dmem_ack) begin
                        mdr   <= dmem_rdata;
                        state <= ST_EXEC;
                    end
                end
                ST_EXEC: begin
                    res  <= alu_out;
                    zr_q <= alu_zr;
                    ng_q <= alu_ng;
                    if (ir[3]) begin
                        state <= ST_MEM_WR;
                    end else begin
                        if (ir[5]) a_reg <= commit_val;
                        if (ir[4]) d_reg <= commit_val;
                        pc    <= commit_pc;
                        state <= ST_FETCH;
                    end
                end
                ST_MEM_WR: begin
                    if (dmem_ack) begin
                        if (ir[5]) a_reg <= commit_val;
                        if (ir[4]) d_reg <= commit_val;
                        pc    <= commit_pc;
                        state <= ST_FETCH;
                    end
                end
`ifdef ILLEGAL_TRAP_EN
                ST_HALT: state <= ST_HALT;
`endif
                default: state <= ST_FETCH;
            endcase
        end
    end

    // Requests are masked while rst is high. This makes any pending handshake
    // drop in the same cycle that reset is applied.
    assign imem_req   = (state == ST_FETCH)  & ~rst;
    assign dmem_rd    = (state == ST_MEM_RD) & ~rst;
    assign dmem_wr    = (state == ST_MEM_WR) & ~rst;
    assign imem_addr  = pc;
    assign dmem_addr  = a_reg[ADDR_W-1:0];
    assign dmem_wdata = res;
    assign alu_x      = d_reg;
    assign alu_y      = ir[12] ? mdr : a_reg;
    assign alu_op     = ir[11:6];
    assign pc_out     = pc;
    assign retire     = ~rst & (((state == ST_DECODE) & ~ir[15]) |
                                ((state == ST_EXEC)   & ~ir[3])  |
                                ((state == ST_MEM_WR) & dmem_ack));

`ifdef ILLEGAL_TRAP_EN
    assign halted = (state == ST_HALT);
`else
    assign halted = 1'b0;
`endif

endmodule

// File: tb/tb_hack_ctrl_seq.sv
// tb_hack_ctrl_seq - self-checking bench for hack_ctrl_seq.
//
// A table of instructions is applied, each with its memory wait profile and
// hand-computed architectural results. The bench acts as the instruction and
// data memories and as a Hack ALU. Hand-written sequences cover a reset
// applied during a read wait and the 0x9000 encoding.
module tb_hack_ctrl_seq;

    logic        clk = 1'b0;
    logic        rst;
    logic        imem_req;
    logic [14:0] imem_addr;
    logic        imem_ack;
    logic [15:0] imem_data;
    logic        dmem_rd;
    logic        dmem_wr;
    logic [14:0] dmem_addr;
    logic [15:0] dmem_wdata;
    logic [15:0] dmem_rdata;
    logic        dmem_ack;
    logic [15:0] alu_x;
    logic [15:0] alu_y;
    logic [5:0]  alu_op;
    logic [15:0] alu_out;
    logic        alu_zr;
    logic        alu_ng;
    logic [14:0] pc_out;
    logic        retire;
    logic        halted;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    hack_ctrl_seq #(.DATA_W(16), .ADDR_W(15), .RESET_PC(0)) dut (
        .clk(clk), .rst(rst),
        .imem_req(imem_req), .imem_addr(imem_addr), .imem_ack(imem_ack), .imem_data(imem_data),
        .dmem_rd(dmem_rd), .dmem_wr(dmem_wr), .dmem_addr(dmem_addr), .dmem_wdata(dmem_wdata),
        .dmem_rdata(dmem_rdata), .dmem_ack(dmem_ack),
        .alu_x(alu_x), .alu_y(alu_y), .alu_op(alu_op),
        .alu_out(alu_out), .alu_zr(alu_zr), .alu_ng(alu_ng),
        .pc_out(pc_out), .retire(retire), .halted(halted)
    );

    // Hack ALU: zx nx zy ny f no
    always_comb begin
        logic [15:0] x, y, o;
        x = alu_op[5] ? 16'h0000 : alu_x;
        x = alu_op[4] ? ~x : x;
        y = alu_op[3] ? 16'h0000 : alu_y;
        y = alu_op[2] ? ~y : y;
        o = alu_op[1] ? (x + y) : (x & y);
        o = alu_op[0] ? ~o : o;
        alu_out = o;
        alu_zr  = (o == 16'h0000);
        alu_ng  = o[15];
    end

    typedef struct {
        logic [15:0] instr;
        int          rd_n;   // cycles dmem_rd is held (0 = no read expected)
        logic [15:0] rdata;
        logic [14:0] raddr;
        int          wr_n;   // cycles dmem_wr is held (0 = no write expected)
        logic [14:0] waddr;
        logic [15:0] wdata;
        logic [14:0] pc;     // PC after retire
        logic [15:0] a;
        logic [15:0] d;
        logic [15:0] y;      // alu_y in the retire cycle (C-instructions)
        int          cyc;    // fetch cycle through retire cycle inclusive
    } vec_t;

    typedef struct {
        logic [14:0] addr;
        logic [15:0] data;
    } wr_t;

    vec_t        vecs[16];
    vec_t        sb[$];
    wr_t         wq[$];
    logic [14:0] model_pc;

    function automatic vec_t mk(input logic [15:0] instr, input int rd_n, input logic [15:0] rdata,
                                input logic [14:0] raddr, input int wr_n, input logic [14:0] waddr,
                                input logic [15:0] wdata, input logic [14:0] pc, input logic [15:0] a,
                                input logic [15:0] d, input logic [15:0] y, input int cyc);
        vec_t v;
        v.instr = instr; v.rd_n = rd_n; v.rdata = rdata; v.raddr = raddr;
        v.wr_n = wr_n; v.waddr = waddr; v.wdata = wdata;
        v.pc = pc; v.a = a; v.d = d; v.y = y; v.cyc = cyc;
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    task automatic do_fetch(input logic [15:0] instr, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 20 && !ok; i++) begin
            @(negedge clk);
            imem_ack = 1'b0;
            dmem_ack = 1'b0;
            #1;
            if (imem_req) begin
                chk("fetch_addr", imem_addr, model_pc);
                imem_data = instr;
                imem_ack  = 1'b1;
                ok        = 1'b1;
            end
        end
        if (!ok) chk("fetch_timeout", 0, 1);
    endtask

    task automatic run_vec(input vec_t v);
        int   cyc, rdc, wrc, rets, guard;
        bit   ok, done;
        vec_t e;
        wr_t  w, wexp;
        cyc = 1; rdc = 0; wrc = 0; rets = 0; guard = 0; done = 1'b0;
        do_fetch(v.instr, ok);
        if (!ok) return;
        sb.push_back(v);
        if (v.wr_n > 0) begin
            w.addr = v.waddr; w.data = v.wdata;
            wq.push_back(w);
        end
        while (!done && guard < 64) begin
            @(negedge clk);
            guard++;
            cyc++;
            imem_ack = 1'b0;
            dmem_ack = 1'b0;
            if (dmem_rd && dmem_wr) chk("rd_wr_overlap", 1, 0);
            if (dmem_rd) begin
                rdc++;
                if (rdc == 1) chk("rd_addr", dmem_addr, v.raddr);
                if (rdc == v.rd_n) begin
                    dmem_rdata = v.rdata;
                    dmem_ack   = 1'b1;
                end
            end
            if (dmem_wr) begin
                wrc++;
                if (wrc == v.wr_n) begin
                    dmem_ack = 1'b1;
                    if (wq.size() == 0) chk("wr_unexpected", 1, 0);
                    else begin
                        wexp = wq.pop_front();
                        chk("wr_addr", dmem_addr, wexp.addr);
                        chk("wr_data", dmem_wdata, wexp.data);
                    end
                end
            end
            #1;
            if (retire) begin
                rets++;
                done = 1'b1;
                if (sb.size() == 0) chk("sb_empty", 1, 0);
                else begin
                    e = sb.pop_front();
                    chk("retire_cycles", cyc, e.cyc);
                    chk("rd_cycles", rdc, e.rd_n);
                    chk("wr_cycles", wrc, e.wr_n);
                    if (e.instr[15]) begin
                        chk("alu_op", alu_op, e.instr[11:6]);
                        chk("alu_y", alu_y, e.y);
                    end
                end
            end
        end
        if (!done) chk("retire_timeout", 0, 1);
        @(negedge clk);
        imem_ack = 1'b0;
        dmem_ack = 1'b0;
        #1;
        chk("retire_once", rets + (retire ? 1 : 0), 1);
        chk("pc", pc_out, v.pc);
        chk("d_reg", alu_x, v.d);
        chk("a_lo", dmem_addr, v.a[14:0]);
        if (!v.instr[12]) chk("a_full", alu_y, v.a);
        model_pc = v.pc;
    endtask

    initial begin
        bit ok;
        int n;
        rst = 1'b1; imem_ack = 1'b0; imem_data = '0;
        dmem_ack = 1'b0; dmem_rdata = '0;
        model_pc = '0;

        //          instr     rd rdata     raddr    wr waddr    wdata     pc        a         d         y        cyc
        vecs[0]  = mk(16'h0005, 0, 16'h0000, 15'h0000, 0, 15'h0000, 16'h0000, 15'h0001, 16'h0005, 16'h0000, 16'h0000, 2);
        vecs[1]  = mk(16'hEDD0, 0, 16'h0000, 15'h0000, 0, 15'h0000, 16'h0000, 15'h0002, 16'h0005, 16'h0006, 16'h0005, 3);
        vecs[2]  = mk(16'h0007, 0, 16'h0000, 15'h0000, 0, 15'h0000, 16'h0000, 15'h0003, 16'h0007, 16'h0006, 16'h0000, 2);
        vecs[3]  = mk(16'hEC10, 0, 16'h0000, 15'h0000, 0, 15'h0000, 16'h0000, 15'h0004, 16'h0007, 16'h0007, 16'h0007, 3);
        vecs[4]  = mk(16'h0010, 0, 16'h0000, 15'h0000, 0, 15'h0000, 16'h0000, 15'h0005, 16'h0010, 16'h0007, 16'h0000, 2);
        vecs[5]  = mk(16'hE308, 0, 16'h0000, 15'h0000, 3, 15'h0010, 16'h0007, 15'h0006, 16'h0010, 16'h0007, 16'h0010, 6);
        vecs[6]  = mk(16'h0020, 0, 16'h0000, 15'h0000, 0, 15'h0000, 16'h0000, 15'h0007, 16'h0020, 16'h0007, 16'h0000, 2);
        vecs[7]  = mk(16'hE301, 0, 16'h0000, 15'h0000, 0, 15'h0000, 16'h0000, 15'h0020, 16'h0020, 16'h0007, 16'h0020, 3);
        vecs[8]  = mk(16'hEE90, 0, 16'h0000, 15'h0000, 0, 15'h0000, 16'h0000, 15'h0021, 16'h0020, 16'hFFFF, 16'h0020, 3);
        vecs[9]  = mk(16'hE301, 0, 16'h0000, 15'h0000, 0, 15'h0000, 16'h0000, 15'h0022, 16'h0020, 16'hFFFF, 16'h0020, 3);
        vecs[10] = mk(16'hEA87, 0, 16'h0000, 15'h0000, 0, 15'h0000, 16'h0000, 15'h0020, 16'h0020, 16'hFFFF, 16'h0020, 3);
        vecs[11] = mk(16'hFC20, 1, 16'h1234, 15'h0020, 0, 15'h0000, 16'h0000, 15'h0021, 16'h1234, 16'hFFFF, 16'h1234, 4);
        vecs[12] = mk(16'hFDEF, 2, 16'h0041, 15'h1234, 1, 15'h1234, 16'h0042, 15'h1234, 16'h0042, 16'hFFFF, 16'h0041, 6);
        vecs[13] = mk(16'h7FFF, 0, 16'h0000, 15'h0000, 0, 15'h0000, 16'h0000, 15'h1235, 16'h7FFF, 16'hFFFF, 16'h0000, 2);
        vecs[14] = mk(16'hEA87, 0, 16'h0000, 15'h0000, 0, 15'h0000, 16'h0000, 15'h7FFF, 16'h7FFF, 16'hFFFF, 16'h7FFF, 3);
        vecs[15] = mk(16'h0003, 0, 16'h0000, 15'h0000, 0, 15'h0000, 16'h0000, 15'h0000, 16'h0003, 16'hFFFF, 16'h0000, 2);

        // Reset state, observed while rst is still held
        @(posedge clk);
        @(negedge clk);
        chk("rst_imem_req", imem_req, 0);
        chk("rst_dmem_rd", dmem_rd, 0);
        chk("rst_dmem_wr", dmem_wr, 0);
        chk("rst_retire", retire, 0);
        chk("rst_halted", halted, 0);
        chk("rst_pc", pc_out, 0);
        chk("rst_d", alu_x, 0);
        chk("rst_a", alu_y, 0);
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;

        foreach (vecs[i]) run_vec(vecs[i]);

        // Reset in the middle of a MEM_RD wait: A=M with the ack withheld
        do_fetch(16'hFC20, ok);
        n = 0;
        for (int i = 0; i < 10 && n < 2; i++) begin
            @(negedge clk);
            imem_ack = 1'b0;
            dmem_ack = 1'b0;
            if (dmem_rd) n++;
        end
        chk("rd_wait_seen", n, 2);
        rst = 1'b1;
        @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        #1;
        chk("mrst_dmem_rd", dmem_rd, 0);
        chk("mrst_fetch", imem_req, 1);
        chk("mrst_retire", retire, 0);
        chk("mrst_pc", pc_out, 0);
        chk("mrst_d", alu_x, 0);
        chk("mrst_a", dmem_addr, 0);
        model_pc = '0;

`ifdef ILLEGAL_TRAP_EN
        do_fetch(16'h9000, ok);
        @(negedge clk);
        imem_ack = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            #1;
            chk("trap_halted", halted, 1);
            chk("trap_imem_req", imem_req, 0);
            chk("trap_retire", retire, 0);
            chk("trap_dmem_rd", dmem_rd, 0);
        end
        rst = 1'b1;
        @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        #1;
        chk("trap_cleared", halted, 0);
        chk("trap_refetch", imem_req, 1);
`else
        // 0x9000 runs as a C-instruction: comp D&M with no dest and no jump
        run_vec(mk(16'h9000, 1, 16'h00FF, 15'h0000, 0, 15'h0000, 16'h0000,
                   15'h0001, 16'h0000, 16'h0000, 16'h00FF, 4));
        chk("no_trap_halted", halted, 0);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
